bus_master_arbiter: RTL and testbench

//   Shares the 68000 bus between the CPU and NREQ alternate masters (DMA, loader, debug probe).

---
 rtl/bus_master_arbiter.sv | 175 +++++++++++++++++
 tb/tb_bus_master_arbiter.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/bus_master_arbiter.sv
// bus_master_arbiter: runs the 68000 BR/BG/BGACK handshake and hands the bus to one of NREQ
// alternate masters round-robin. Define BUS_ARB_TIMEOUT_EN for the ownership counter / forced revoke.
module bus_master_arbiter #(
    parameter int NREQ     = 2,
    parameter int CW       = 8,
    parameter int HOLD_MAX = 255,
    parameter int CPU_GAP  = 4
) (
    input  logic            MCLK_IN,
    input  logic            RESET_IN,
    input  logic            AS_IN,
    input  logic            BG_IN,
    input  logic [NREQ-1:0] REQ_IN,
    input  logic [NREQ-1:0] DONE_IN,
    output logic            BR,
    output logic            BGACK,
    output logic [NREQ-1:0] GNT,
    output logic            TIMEOUT
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARB,
        ST_WAITBUS,
        ST_OWN,
        ST_REL
    } state_t;

    if (NREQ < 1 || NREQ > 8 || CPU_GAP < 1 || CPU_GAP > (2**CW - 1) ||
        HOLD_MAX < 1 || HOLD_MAX > (2**CW - 1)) begin : g_param_check
        $error("bus_master_arbiter: parameter out of range");
    end

    state_t          state_q, state_d;
    logic            br_q, br_d;
    logic            bgack_q, bgack_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [IW-1:0]   winner_q, winner_d;
    logic [CW-1:0]   gap_q, gap_d;
`ifdef BUS_ARB_TIMEOUT_EN
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            timeout_q, timeout_d;
`endif

    // First requester at or after the round-robin pointer, wrapping around.
    function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IW-1:0]   ptr);
        logic [IW-1:0] pick;
        logic          found;
        int            idx;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(ptr) + k) % NREQ;
            if (!found && req[idx]) begin
                pick  = IW'(idx);
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        state_d  = state_q;
        br_d     = br_q;
        bgack_d  = bgack_q;
        gnt_d    = gnt_q;
        rr_d     = rr_q;
        winner_d = winner_q;
        gap_d    = gap_q;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gap_q != '0) begin
                    gap_d = gap_q - 1'b1;
                end else if (|REQ_IN) begin
                    br_d    = 1'b1;
                    state_d = ST_ARB;
                end
            end
            ST_ARB: begin
                if (REQ_IN == '0) begin
                    br_d    = 1'b0;
                    state_d = ST_IDLE;
                end else if (BG_IN) begin
                    winner_d = rr_pick(REQ_IN, rr_q);
                    state_d  = ST_WAITBUS;
                end
            end
            ST_WAITBUS: begin
                // A withdrawn winner takes priority over the CPU finishing its cycle.
                if (!REQ_IN[winner_q]) begin
                    br_d    = 1'b0;
                    state_d = ST_REL;
                end else if (!AS_IN) begin
                    bgack_d = 1'b1;
                    gnt_d   = NREQ'(1) << winner_q;
                    br_d    = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                    state_d = ST_OWN;
                end
            end
            ST_OWN: begin
                if (DONE_IN[winner_q] || !REQ_IN[winner_q]) begin
                    gnt_d   = '0;
                    state_d = ST_REL;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (cnt_q == CW'(HOLD_MAX - 1)) begin
                    gnt_d     = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_REL;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            ST_REL: begin
                // BGACK lingers one cycle so the master can tri-state. BGACK drops on this
                // edge, so the gap counter loads one less to keep BR low exactly CPU_GAP cycles.
                bgack_d = 1'b0;
                rr_d    = (winner_q == IW'(NREQ - 1)) ? '0 : winner_q + 1'b1;
                gap_d   = CW'(CPU_GAP - 1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge MCLK_IN or posedge RESET_IN) begin
        if (RESET_IN) begin
            state_q   <= ST_IDLE;
            br_q      <= 1'b0;
            bgack_q   <= 1'b0;
            gnt_q     <= '0;
            rr_q      <= '0;
            winner_q  <= '0;
            gap_q     <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q     <= '0;
            timeout_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            br_q      <= br_d;
            bgack_q   <= bgack_d;
            gnt_q     <= gnt_d;
            rr_q      <= rr_d;
            winner_q  <= winner_d;
            gap_q     <= gap_d;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
`endif
        end
    end

    assign BR    = br_q;
    assign BGACK = bgack_q;
    assign GNT   = gnt_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign TIMEOUT = timeout_q;
`else
    assign TIMEOUT = 1'b0;
`endif

endmodule

// File: tb/tb_bus_master_arbiter.sv
// Directed bench for bus_master_arbiter: handshake, fairness, timeout/hold, withdraw and reset abort.
module tb_bus_master_arbiter;

    logic       MCLK_IN = 1'b0;
    logic       RESET_IN;
    logic       AS_IN;
    logic       BG_IN;
    logic [1:0] REQ_IN;
    logic [1:0] DONE_IN;
    logic       BR;
    logic       BGACK;
    logic [1:0] GNT;
    logic       TIMEOUT;

    int total = 0;
    int bad   = 0;
    logic [1:0] exp_q[$];

    bus_master_arbiter #(
        .NREQ(2), .CW(8), .HOLD_MAX(8), .CPU_GAP(4)
    ) dut (
        .MCLK_IN(MCLK_IN), .RESET_IN(RESET_IN), .AS_IN(AS_IN), .BG_IN(BG_IN),
        .REQ_IN(REQ_IN), .DONE_IN(DONE_IN), .BR(BR), .BGACK(BGACK), .GNT(GNT),
        .TIMEOUT(TIMEOUT)
    );

    always #5 MCLK_IN = ~MCLK_IN;

    task automatic tick();
        @(posedge MCLK_IN);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for the next grant, then compare it against the scoreboard head.
    task automatic wait_grant(input string tag);
        int n = 0;
        logic [1:0] exp;
        while (GNT == 2'b00 && n < 60) begin
            tick();
            n++;
        end
        exp = (exp_q.size() != 0) ? exp_q.pop_front() : 2'b00;
        chk(tag, 32'(GNT), 32'(exp));
    endtask

    initial begin
        int   n;
        logic sticky;

        RESET_IN = 1'b1;
        AS_IN    = 1'b1;
        BG_IN    = 1'b0;
        REQ_IN   = 2'b00;
        DONE_IN  = 2'b00;
        tick();
        tick();
        chk("reset_outs", 32'({BR, BGACK, GNT, TIMEOUT}), 32'd0);
        RESET_IN = 1'b0;
        tick();

        // single grant
        REQ_IN = 2'b01;
        tick();
        chk("br_rise", 32'(BR), 32'd1);
        BG_IN = 1'b1;
        tick();
        tick();
        chk("no_gnt_as_high", 32'(GNT), 32'd0);
        chk("br_held_waitbus", 32'(BR), 32'd1);
        exp_q.push_back(2'b01);
        AS_IN = 1'b0;
        tick();
        wait_grant("single_gnt");
        chk("single_bgack", 32'(BGACK), 32'd1);
        chk("single_br_low", 32'(BR), 32'd0);
        BG_IN   = 1'b0;
        DONE_IN = 2'b01;
        tick();
        DONE_IN = 2'b00;
        chk("gnt_drop", 32'(GNT), 32'd0);
        chk("bgack_linger", 32'(BGACK), 32'd1);
        tick();
        chk("bgack_drop", 32'(BGACK), 32'd0);
        n = 0;
        while (!BR && n < 20) begin
            n++;
            tick();
        end
        chk("cpu_gap_len", 32'(n), 32'd4);

        // withdraw before BG
        REQ_IN = 2'b00;
        tick();
        chk("withdraw_br", 32'(BR), 32'd0);
        sticky = 1'b0;
        repeat (5) begin
            if (GNT != 2'b00) sticky = 1'b1;
            tick();
        end
        chk("withdraw_no_gnt", 32'(sticky), 32'd0);

        // reset clears the rr pointer (left at 1 above)
        RESET_IN = 1'b1;
        #2;
        chk("reset2_outs", 32'({BR, BGACK, GNT, TIMEOUT}), 32'd0);
        tick();
        RESET_IN = 1'b0;

        // fairness
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        exp_q.push_back(2'b01);
        exp_q.push_back(2'b10);
        REQ_IN = 2'b11;
        BG_IN  = 1'b1;
        AS_IN  = 1'b0;
        for (int g = 0; g < 4; g++) begin
            wait_grant($sformatf("fair_gnt%0d", g));
            chk($sformatf("fair_bgack%0d", g), 32'(BGACK), 32'd1);
            tick();
            tick();
            DONE_IN = GNT;
            tick();
            DONE_IN = 2'b00;
            chk($sformatf("fair_drop%0d", g), 32'(GNT), 32'd0);
        end
        REQ_IN = 2'b00;
        repeat (3) tick();

`ifdef BUS_ARB_TIMEOUT_EN
        // forced revoke after HOLD_MAX cycles
        REQ_IN = 2'b01;
        exp_q.push_back(2'b01);
        wait_grant("tmo_gnt");
        n = 0;
        sticky = 1'b0;
        while (GNT != 2'b00 && n < 40) begin
            if (TIMEOUT) sticky = 1'b1;
            n++;
            tick();
        end
        chk("tmo_hold_len", 32'(n), 32'd8);
        chk("tmo_no_early", 32'(sticky), 32'd0);
        chk("tmo_pulse", 32'(TIMEOUT), 32'd1);
        tick();
        chk("tmo_pulse_end", 32'(TIMEOUT), 32'd0);
        exp_q.push_back(2'b01);
        wait_grant("tmo2_gnt");
        repeat (7) tick();
        chk("tmo2_still_own", 32'(GNT), 32'd1);
        DONE_IN = 2'b01;
        tick();
        DONE_IN = 2'b00;
        chk("tmo2_drop", 32'(GNT), 32'd0);
        chk("tmo2_done_wins", 32'(TIMEOUT), 32'd0);
`else
        // no timeout build: ownership persists until DONE
        REQ_IN = 2'b01;
        exp_q.push_back(2'b01);
        wait_grant("hold_gnt");
        sticky = 1'b0;
        repeat (20) begin
            tick();
            if (GNT != 2'b01 || TIMEOUT) sticky = 1'b1;
        end
        chk("hold_no_revoke", 32'(sticky), 32'd0);
        DONE_IN = 2'b01;
        tick();
        DONE_IN = 2'b00;
        chk("hold_drop", 32'(GNT), 32'd0);
`endif
        REQ_IN = 2'b00;
        repeat (3) tick();

        // abort with reset while master 1 owns the bus
        REQ_IN = 2'b11;
        exp_q.push_back(2'b10);
        wait_grant("abort_gnt");
        chk("abort_bgack", 32'(BGACK), 32'd1);
        #2;
        RESET_IN = 1'b1;
        #1;
        chk("abort_outs", 32'({BR, BGACK, GNT, TIMEOUT}), 32'd0);
        tick();
        tick();
        RESET_IN = 1'b0;
        exp_q.push_back(2'b01);
        wait_grant("abort_restart");
        DONE_IN = GNT;
        tick();
        DONE_IN = 2'b00;
        REQ_IN  = 2'b00;
        chk("final_drop", 32'(GNT), 32'd0);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
